seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode/cathode seven-segment bank on the calculator front panel.
//  Holds a packed BCD/hex value, scans one digit per slot, and decodes each nibble to GFEDCBA segments (bit0=A).
//  Successor to the single-digit decoder: adds scanning, hex mode, leading-zero blanking, decimal points,
//  anti-ghost blanking and tear-free frame-aligned value updates.
// PARAMETERS
//  NUM_DIGITS   4      digits in bank, legal 1..8
//  SCAN_DIV     50000  clk cycles per digit slot, legal >= 2
//  BLANK_CYC    4      cycles at slot start with all anodes off, legal 0..SCAN_DIV-1
//  SEG_ACT_LOW  0      1: seg_o/dp_o active-low
//  AN_ACT_LOW   0      1: an_o active-low
// PORTS
//  clk         in   1             system clock, rising edge
//  rst_n       in   1             async active-low reset
//  value_i     in   4*NUM_DIGITS  nibble k = digit k, digit 0 rightmost
//  dp_i        in   NUM_DIGITS    decimal point per digit, captured with value_i
//  load_i      in   1             1-cycle strobe: capture value_i/dp_i into pending regs
//  hex_mode_i  in   1             1: nibbles 10..15 show A b C d E F; 0: they show blank
//  blank_lz_i  in   1             1: suppress leading zeros
//  seg_o       out  7             segments GFEDCBA of currently driven digit
//  dp_o        out  1             decimal point of currently driven digit
//  an_o        out  NUM_DIGITS    one-hot digit enable (or all off)
//  frame_o     out  1             1-cycle pulse when digit index wraps NUM_DIGITS-1 -> 0
// BEHAVIOUR
//  Reset (async assert, sync release): cnt=0, idx=0, pending/display regs=0, an_o/seg_o/dp_o inactive, frame_o=0.
//  Reset mid-scan forces all outputs inactive immediately; scan restarts at digit 0, slot cycle 0.
//  Slot counter cnt: 0..SCAN_DIV-1, +1 per clk; at SCAN_DIV-1 wraps to 0 and idx advances.
//  idx: 0..NUM_DIGITS-1; at NUM_DIGITS-1 with cnt wrap -> 0 and frame_o=1 in that wrap's next cycle.
//  NUM_DIGITS=1: idx fixed at 0; frame_o pulses every slot.
//  Outputs registered: an_o/seg_o/dp_o reflect (idx,cnt) of previous cycle (1-cycle latency).
//  an_o: all inactive while registered cnt < BLANK_CYC; else bit idx active only.
//  seg_o/dp_o: decoded from display nibble idx; driven even during blanking (anodes gate them).
//  Decode: 0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F; A 77,b 7C,C 39,d 5E,E 79,F 71 (hex_mode_i=1)
//   else 10..15 -> 00. Polarity inversion applied after decode.
//  Leading-zero blank (blank_lz_i=1): digit k>0 blanked (seg 00) if nibble k and all higher nibbles are 0;
//   digit 0 never blanked; dp_o still follows dp bit; a set dp on digit k stops blanking at k and below.
//  Update: load_i writes pending regs; display regs copy pending at each idx wrap (frame boundary).
//   load_i in same cycle as wrap: value_i/dp_i go straight to display regs (bypass). Back-to-back loads: last wins.
//  hex_mode_i, blank_lz_i sampled live every cycle (not frame aligned).
// STRUCTURE
//  Package seven_seg_pkg: SEG_W=7 localparam, seg_t typedef, SEG_* table constants, SEG_BLANK=7'h00.
//  Sub-module seven_seg_decode (comb): nibble, hex_mode -> seg_t. Instantiated once, on muxed nibble.
//  Top holds cnt/idx counters, pending/display regs, LZ mask logic, output flops. Elaborate-time asserts on params.
// TESTING (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, active-high)
//  Reset, load 16'h1234 -> after first frame_o, an_o cycles 0001,0010,0100,1000; seg 4F(d0=4? no: d0=4 -> 66),4F,5B,06.
//  Blanking: per slot an_o==0 for exactly 2 cycles then one-hot for 6; frame_o period = 32 cycles.
//  LZ: load 16'h0007, blank_lz_i=1 -> digits 3..1 seg 00, digit 0 seg 07; blank_lz_i=0 -> 3F,3F,3F,07.
//  Hex: load 16'hABCF, hex_mode_i=1 -> 71,39,7C,77 on d0..d3; hex_mode_i=0 -> all 00.
//  Tear-free: load 16'h1111 mid-frame -> current frame still old value; load on wrap cycle -> applies that frame.
//  rst_n low mid-slot (idx=2,cnt=5) -> an_o=0 same cycle; after release first active digit is 0 after 2 blank cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and segment patterns for the seven-segment scan driver.
// Segment bit order is GFEDCBA with bit0 = segment A, active-high patterns;
// any output polarity inversion is applied by the driver after decode.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Front-panel display bus between the value source and the scan driver.
//   value_i    packed nibbles, nibble k = digit k, digit 0 rightmost
//   dp_i       decimal point per digit, captured together with value_i
//   load_i     one-cycle capture strobe
//   hex_mode_i show 10..15 as A b C d E F (else blank)
//   blank_lz_i suppress leading zeros
//   seg_o      GFEDCBA of the digit currently driven
//   dp_o       decimal point of the digit currently driven
//   an_o       one-hot digit enable, or all off
//   frame_o    one-cycle pulse when the scan wraps back to digit 0
// master: value source / panel controller.  slave: the scan driver.
interface seven_seg_scan_driver_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  logic [4*NUM_DIGITS-1:0] value_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic                    load_i;
  logic                    hex_mode_i;
  logic                    blank_lz_i;
  seg_t                    seg_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic                    frame_o;

  modport master (
    output value_i, dp_i, load_i, hex_mode_i, blank_lz_i,
    input  seg_o, dp_o, an_o, frame_o
  );

  modport slave (
    input  value_i, dp_i, load_i, hex_mode_i, blank_lz_i,
    output seg_o, dp_o, an_o, frame_o
  );

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational nibble to GFEDCBA decoder (active-high patterns).
//   nibble   value 0..15
//   hex_mode 1: 10..15 render as A b C d E F; 0: they render blank
//   seg      decoded segment pattern
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver.
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   display bus (slave side): value/dp/load/mode inputs,
//         seg/dp/an/frame registered outputs
// One digit is driven per slot of SCAN_DIV cycles; the first BLANK_CYC cycles
// of each slot keep all anodes off so the previous digit cannot ghost.
// New values land in pending registers and are copied to the display
// registers only at the frame boundary, so a frame never shows a mix.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 4,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_seg_scan_driver_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_INV  = {SEG_W{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_INV   = {NUM_DIGITS{AN_ACT_LOW}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seven_seg_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seven_seg_scan_driver: SCAN_DIV must be >= 2");
  end
  if (BLANK_CYC < 0 || BLANK_CYC > SCAN_DIV - 1) begin : g_bad_blank_cyc
    $error("seven_seg_scan_driver: BLANK_CYC must be 0..SCAN_DIV-1");
  end

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_wrap;
  logic                  frame_wrap;

  logic [VAL_W-1:0]      pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [VAL_W-1:0]      disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_above;
  logic [3:0]            cur_nib;
  seg_t                  dec_seg;
  seg_t                  seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  seg_t                  seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_q;

  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= frame_wrap ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load coinciding with the frame wrap bypasses the pending registers so
  // the new value is shown from the very frame that starts next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (bus.load_i) begin
        pend_val <= bus.value_i;
        pend_dp  <= bus.dp_i;
      end
      if (frame_wrap) begin
        disp_val <= bus.load_i ? bus.value_i : pend_val;
        disp_dp  <= bus.load_i ? bus.dp_i    : pend_dp;
      end
    end
  end

  // Digit k (k > 0) is a leading zero when it and every higher digit hold a
  // zero nibble with no decimal point lit.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (disp_val[4*k +: 4] == 4'h0) && !disp_dp[k];
      lz_blank[k] = zero_above;
    end
  end

  assign cur_nib = disp_val[4*int'(idx) +: 4];

  seven_seg_decode u_decode (
    .nibble   (cur_nib),
    .hex_mode (bus.hex_mode_i),
    .seg      (dec_seg)
  );

  always_comb begin
    an_nxt = '0;
    if (int'(cnt) >= BLANK_CYC) begin
      an_nxt[idx] = 1'b1;
    end
    seg_nxt = (bus.blank_lz_i && lz_blank[idx]) ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= AN_INV;
      seg_q   <= SEG_INV;
      dp_q    <= SEG_ACT_LOW;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_nxt ^ AN_INV;
      seg_q   <= seg_nxt ^ SEG_INV;
      dp_q    <= disp_dp[idx] ^ SEG_ACT_LOW;
      frame_q <= frame_wrap;
    end
  end

  assign bus.an_o    = an_q;
  assign bus.seg_o   = seg_q;
  assign bus.dp_o    = dp_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;
  import seven_seg_pkg::*;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int B  = 2;
  localparam int FR = S * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus_if ();

  seven_seg_scan_driver #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (S),
    .BLANK_CYC   (B),
    .SEG_ACT_LOW (1'b0),
    .AN_ACT_LOW  (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] model_seg(logic [3:0] nib, logic hex);
    if (nib > 4'd9 && !hex) return 7'h00;
    return dec_tab[nib];
  endfunction

  // Reference model: scan position is simply the number of clocks since
  // reset release; everything else follows by division and modulo.
  initial begin : model
    int n, d, c;
    logic [15:0] mp, md;
    logic [3:0]  dpp, dpd;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fr;
    n = 0; mp = '0; md = '0; dpp = '0; dpd = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; mp = '0; md = '0; dpp = '0; dpd = '0;
        e_an = '0; e_seg = '0; e_dp = 1'b0; e_fr = 1'b0;
      end else begin
        d     = (n / S) % N;
        c     = n % S;
        e_an  = (c < B) ? 4'b0000 : 4'(1 << d);
        e_seg = model_seg(4'(md >> (4 * d)), bus_if.hex_mode_i);
        if (bus_if.blank_lz_i && d > 0 && (md >> (4 * d)) == 16'h0 && (dpd >> d) == 4'h0)
          e_seg = 7'h00;
        e_dp  = dpd[d];
        e_fr  = (n % FR == FR - 1);
        if (bus_if.load_i) begin
          mp  = bus_if.value_i;
          dpp = bus_if.dp_i;
        end
        if (n % FR == FR - 1) begin
          md  = mp;
          dpd = dpp;
        end
        n++;
      end
      #1;
      checks++;
      if (bus_if.an_o !== e_an || bus_if.seg_o !== e_seg ||
          bus_if.dp_o !== e_dp || bus_if.frame_o !== e_fr) begin
        errors++;
        $display("FAIL scan_model t=%0t an %b/%b seg %h/%h dp %b/%b frame %b/%b (got/exp)",
                 $time, bus_if.an_o, e_an, bus_if.seg_o, e_seg,
                 bus_if.dp_o, e_dp, bus_if.frame_o, e_fr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus_if.frame_o) return;
    end
    checks++; errors++;
    $display("FAIL wait_frame timeout got no frame_o expected pulse within 100 cycles");
  endtask

  task automatic wait_digit(input int d);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.an_o == 4'(1 << d)) return;
    end
    checks++; errors++;
    $display("FAIL wait_digit%0d timeout got an_o %b expected one-hot digit", d, bus_if.an_o);
  endtask

  task automatic check_digit(input int d, input logic [6:0] exp_seg, input string name);
    wait_digit(d);
    chk(name, 32'(bus_if.seg_o), 32'(exp_seg));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    @(negedge clk);
    bus_if.value_i = v;
    bus_if.dp_i    = p;
    bus_if.load_i  = 1'b1;
    @(negedge clk);
    bus_if.load_i  = 1'b0;
  endtask

  initial begin : stim
    int cycles, blanks;
    bus_if.value_i    = '0;
    bus_if.dp_i       = '0;
    bus_if.load_i     = 1'b0;
    bus_if.hex_mode_i = 1'b0;
    bus_if.blank_lz_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_an",    32'(bus_if.an_o),    32'h0);
    chk("reset_seg",   32'(bus_if.seg_o),   32'h0);
    chk("reset_frame", 32'(bus_if.frame_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // basic scan of 1234
    do_load(16'h1234, 4'h0);
    wait_frame();
    check_digit(0, 7'h66, "d0_1234");
    check_digit(1, 7'h4F, "d1_1234");
    check_digit(2, 7'h5B, "d2_1234");
    check_digit(3, 7'h06, "d3_1234");

    // frame period and anti-ghost blank cycles
    wait_frame();
    cycles = 0; blanks = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (bus_if.an_o == 4'b0000) blanks++;
    end while (!bus_if.frame_o && cycles < 100);
    chk("frame_period", 32'(cycles), 32'd32);
    chk("blank_cycles", 32'(blanks), 32'd8);

    // leading-zero blanking
    bus_if.blank_lz_i = 1'b1;
    do_load(16'h0007, 4'h0);
    wait_frame();
    check_digit(0, 7'h07, "lz_d0");
    check_digit(1, 7'h00, "lz_d1");
    check_digit(2, 7'h00, "lz_d2");
    check_digit(3, 7'h00, "lz_d3");
    @(negedge clk) bus_if.blank_lz_i = 1'b0;
    check_digit(1, 7'h3F, "nolz_d1");
    check_digit(2, 7'h3F, "nolz_d2");
    check_digit(3, 7'h3F, "nolz_d3");

    // a lit decimal point stops blanking at its digit and below
    bus_if.blank_lz_i = 1'b1;
    do_load(16'h0007, 4'b0100);
    wait_frame();
    check_digit(1, 7'h3F, "lzdp_d1");
    check_digit(2, 7'h3F, "lzdp_d2");
    chk("lzdp_d2_dp", 32'(bus_if.dp_o), 32'h1);
    check_digit(3, 7'h00, "lzdp_d3");
    bus_if.blank_lz_i = 1'b0;

    // hex mode
    bus_if.hex_mode_i = 1'b1;
    do_load(16'hABCF, 4'h0);
    wait_frame();
    check_digit(0, 7'h71, "hex_d0");
    check_digit(1, 7'h39, "hex_d1");
    check_digit(2, 7'h7C, "hex_d2");
    check_digit(3, 7'h77, "hex_d3");
    @(negedge clk) bus_if.hex_mode_i = 1'b0;
    check_digit(0, 7'h00, "nohex_d0");
    check_digit(1, 7'h00, "nohex_d1");
    check_digit(2, 7'h00, "nohex_d2");
    check_digit(3, 7'h00, "nohex_d3");

    // tear-free: mid-frame load waits for the next frame
    @(negedge clk) bus_if.hex_mode_i = 1'b1;
    wait_frame();
    do_load(16'h1111, 4'h0);
    check_digit(1, 7'h39, "tear_old_d1");
    check_digit(2, 7'h7C, "tear_old_d2");
    check_digit(3, 7'h77, "tear_old_d3");
    wait_frame();
    check_digit(0, 7'h06, "tear_new_d0");

    // load exactly on the wrap cycle applies to the frame that starts next
    wait_frame();
    repeat (31) @(posedge clk);
    do_load(16'h2222, 4'h0);
    check_digit(0, 7'h5B, "wrap_bypass_d0");

    // reset in the middle of digit 2's slot
    wait_frame();
    repeat (21) @(posedge clk);
    #1;
    chk("pre_reset_an", 32'(bus_if.an_o), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_an",  32'(bus_if.an_o),  32'h0);
    chk("midrst_seg", 32'(bus_if.seg_o), 32'h0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_blank0", 32'(bus_if.an_o), 32'h0);
    @(posedge clk); #1;
    chk("post_rst_blank1", 32'(bus_if.an_o), 32'h0);
    @(posedge clk); #1;
    chk("post_rst_first",  32'(bus_if.an_o), 32'h1);
    chk("post_rst_seg",    32'(bus_if.seg_o), 32'h3F);

    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
